// File: rtl/dsp_axil_regs.sv
// rtl/dsp_axil_regs.sv - AXI-Lite register block for DSP accelerator control, status and result capture.
// Optional IRQ_EN/IRQ_STAT registers and irq_o are enabled by defining DSP_REGS_IRQ_EN.
module dsp_axil_regs #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr_i,
    input  logic                    s_axi_awvalid_i,
    output logic                    s_axi_awready_o,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb_i,
    input  logic                    s_axi_wvalid_i,
    output logic                    s_axi_wready_o,
    output logic [1:0]              s_axi_bresp_o,
    output logic                    s_axi_bvalid_o,
    input  logic                    s_axi_bready_i,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr_i,
    input  logic                    s_axi_arvalid_i,
    output logic                    s_axi_arready_o,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata_o,
    output logic [1:0]              s_axi_rresp_o,
    output logic                    s_axi_rvalid_o,
    input  logic                    s_axi_rready_i,
    output logic                    core_start_o,
    output logic [DATA_WIDTH-1:0]   core_src_addr_o,
    output logic [DATA_WIDTH-1:0]   core_dst_addr_o,
    output logic [LEN_WIDTH-1:0]    core_len_o,
    input  logic                    core_busy_i,
    input  logic                    core_done_i,
    input  logic [DATA_WIDTH-1:0]   core_result_i,
    output logic                    irq_o
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_STATUS   = 3'd1;
    localparam logic [2:0] REG_SRC      = 3'd2;
    localparam logic [2:0] REG_DST      = 3'd3;
    localparam logic [2:0] REG_LEN      = 3'd4;
    localparam logic [2:0] REG_RESULT   = 3'd5;
    localparam logic [2:0] REG_IRQ_EN   = 3'd6;
    localparam logic [2:0] REG_IRQ_STAT = 3'd7;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;
    logic                  bvalid_q, rvalid_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [DATA_WIDTH-1:0] src_q, dst_q, result_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic                  done_q, start_q;

    logic                  aw_fire, w_fire, ar_fire, commit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_WIDTH-1:0] wr_strb;
    logic [2:0]            wr_idx, rd_idx;
    logic                  wr_mapped, wr_byte0, start_req, clear_done;
    logic [DATA_WIDTH-1:0] src_merged, dst_merged, len_merged, len_ext;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [1:0]            rd_resp;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] new_val,
        input logic [STRB_WIDTH-1:0] strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_val;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

    function automatic logic is_mapped(input logic [2:0] idx);
`ifdef DSP_REGS_IRQ_EN
        is_mapped = 1'b1;
        if (idx == 3'd0) is_mapped = 1'b1;
`else
        is_mapped = (idx != REG_IRQ_EN) && (idx != REG_IRQ_STAT);
`endif
    endfunction

    assign s_axi_awready_o = !aw_held && !bvalid_q;
    assign s_axi_wready_o  = !w_held && !bvalid_q;
    assign s_axi_arready_o = !rvalid_q;
    assign s_axi_bvalid_o  = bvalid_q;
    assign s_axi_bresp_o   = bresp_q;
    assign s_axi_rvalid_o  = rvalid_q;
    assign s_axi_rresp_o   = rresp_q;
    assign s_axi_rdata_o   = rdata_q;

    assign aw_fire = s_axi_awvalid_i && s_axi_awready_o;
    assign w_fire  = s_axi_wvalid_i && s_axi_wready_o;
    assign ar_fire = s_axi_arvalid_i && s_axi_arready_o;

    // Commit on the edge where the later of AW/W arrives, using the live channel if not yet held.
    assign commit  = (aw_held || aw_fire) && (w_held || w_fire);
    assign wr_addr = aw_held ? aw_addr_q : s_axi_awaddr_i;
    assign wr_data = w_held ? w_data_q : s_axi_wdata_i;
    assign wr_strb = w_held ? w_strb_q : s_axi_wstrb_i;
    assign wr_idx  = wr_addr[4:2];
    assign rd_idx  = s_axi_araddr_i[4:2];

    assign wr_mapped  = is_mapped(wr_idx);
    assign wr_byte0   = commit && wr_strb[0];
    assign start_req  = wr_byte0 && (wr_idx == REG_CTRL) && wr_data[0] && !core_busy_i;
    assign clear_done = wr_byte0 && (wr_idx == REG_STATUS) && wr_data[1];

    assign len_ext    = {{(DATA_WIDTH-LEN_WIDTH){1'b0}}, len_q};
    assign src_merged = merge_bytes(src_q, wr_data, wr_strb);
    assign dst_merged = merge_bytes(dst_q, wr_data, wr_strb);
    assign len_merged = merge_bytes(len_ext, wr_data, wr_strb);

`ifdef DSP_REGS_IRQ_EN
    logic irq_en_q, irq_stat_q, irq_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            irq_en_q   <= 1'b0;
            irq_stat_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            if (wr_byte0 && wr_idx == REG_IRQ_EN) irq_en_q <= wr_data[0];
            // A completion in the same cycle as the W1C clear keeps the status set.
            if (core_done_i)
                irq_stat_q <= 1'b1;
            else if (wr_byte0 && wr_idx == REG_IRQ_STAT && wr_data[0])
                irq_stat_q <= 1'b0;
            irq_q <= irq_en_q && irq_stat_q;
        end
    end
    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        rd_resp = is_mapped(rd_idx) ? RESP_OKAY : RESP_SLVERR;
        case (rd_idx)
            REG_STATUS:   rd_data[1:0] = {done_q, core_busy_i};
            REG_SRC:      rd_data = src_q;
            REG_DST:      rd_data = dst_q;
            REG_LEN:      rd_data = len_ext;
            REG_RESULT:   rd_data = result_q;
`ifdef DSP_REGS_IRQ_EN
            REG_IRQ_EN:   rd_data[0] = irq_en_q;
            REG_IRQ_STAT: rd_data[0] = irq_stat_q;
`endif
            default:      rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            if (aw_fire) aw_addr_q <= s_axi_awaddr_i;
            if (w_fire) begin
                w_data_q <= s_axi_wdata_i;
                w_strb_q <= s_axi_wstrb_i;
            end
            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
            end else begin
                aw_held <= aw_held || aw_fire;
                w_held  <= w_held || w_fire;
                if (bvalid_q && s_axi_bready_i) bvalid_q <= 1'b0;
            end
            if (ar_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
                rresp_q  <= rd_resp;
            end else if (rvalid_q && s_axi_rready_i) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            start_q <= start_req;
            if (commit && wr_idx == REG_SRC) src_q <= src_merged;
            if (commit && wr_idx == REG_DST) dst_q <= dst_merged;
            if (commit && wr_idx == REG_LEN) len_q <= len_merged[LEN_WIDTH-1:0];
            if (core_done_i) result_q <= core_result_i;
            if (core_done_i)
                done_q <= 1'b1;
            else if (clear_done)
                done_q <= 1'b0;
        end
    end

    assign core_start_o    = start_q;
    assign core_src_addr_o = src_q;
    assign core_dst_addr_o = dst_q;
    assign core_len_o      = len_q;

    logic unused_ok;
    assign unused_ok = ^{wr_addr[1:0], s_axi_araddr_i[1:0], len_merged[DATA_WIDTH-1:LEN_WIDTH]};
endmodule

// File: tb/tb_dsp_axil_regs.sv
// tb/tb_dsp_axil_regs.sv - Directed scoreboard bench for dsp_axil_regs.
module tb_dsp_axil_regs;
    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic [4:0]  s_axi_awaddr_i = '0;
    logic        s_axi_awvalid_i = 1'b0;
    logic        s_axi_awready_o;
    logic [31:0] s_axi_wdata_i = '0;
    logic [3:0]  s_axi_wstrb_i = '0;
    logic        s_axi_wvalid_i = 1'b0;
    logic        s_axi_wready_o;
    logic [1:0]  s_axi_bresp_o;
    logic        s_axi_bvalid_o;
    logic        s_axi_bready_i = 1'b1;
    logic [4:0]  s_axi_araddr_i = '0;
    logic        s_axi_arvalid_i = 1'b0;
    logic        s_axi_arready_o;
    logic [31:0] s_axi_rdata_o;
    logic [1:0]  s_axi_rresp_o;
    logic        s_axi_rvalid_o;
    logic        s_axi_rready_i = 1'b1;
    logic        core_start_o;
    logic [31:0] core_src_addr_o, core_dst_addr_o;
    logic [15:0] core_len_o;
    logic        core_busy_i = 1'b0;
    logic        core_done_i = 1'b0;
    logic [31:0] core_result_i = '0;
    logic        irq_o;

    int checks = 0;
    int errors = 0;
    int start_cycles = 0;
    logic [1:0]  exp_b_q[$];
    logic [33:0] exp_r_q[$];

    dsp_axil_regs dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .s_axi_awaddr_i(s_axi_awaddr_i), .s_axi_awvalid_i(s_axi_awvalid_i), .s_axi_awready_o(s_axi_awready_o),
        .s_axi_wdata_i(s_axi_wdata_i), .s_axi_wstrb_i(s_axi_wstrb_i), .s_axi_wvalid_i(s_axi_wvalid_i),
        .s_axi_wready_o(s_axi_wready_o),
        .s_axi_bresp_o(s_axi_bresp_o), .s_axi_bvalid_o(s_axi_bvalid_o), .s_axi_bready_i(s_axi_bready_i),
        .s_axi_araddr_i(s_axi_araddr_i), .s_axi_arvalid_i(s_axi_arvalid_i), .s_axi_arready_o(s_axi_arready_o),
        .s_axi_rdata_o(s_axi_rdata_o), .s_axi_rresp_o(s_axi_rresp_o), .s_axi_rvalid_o(s_axi_rvalid_o),
        .s_axi_rready_i(s_axi_rready_i),
        .core_start_o(core_start_o), .core_src_addr_o(core_src_addr_o), .core_dst_addr_o(core_dst_addr_o),
        .core_len_o(core_len_o), .core_busy_i(core_busy_i), .core_done_i(core_done_i),
        .core_result_i(core_result_i), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) if (core_start_o === 1'b1) start_cycles++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] resp, input bit with_done);
        bit aw_pend, w_pend, a_acc, w_acc;
        int n;
        logic [1:0] exp_resp;
        exp_b_q.push_back(resp);
        s_axi_awaddr_i = addr; s_axi_wdata_i = data; s_axi_wstrb_i = strb;
        s_axi_awvalid_i = 1'b1; s_axi_wvalid_i = 1'b1; s_axi_bready_i = 1'b1;
        if (with_done) core_done_i = 1'b1;
        aw_pend = 1'b1; w_pend = 1'b1; n = 0;
        while ((aw_pend || w_pend) && n < 20) begin
            a_acc = s_axi_awvalid_i && s_axi_awready_o;
            w_acc = s_axi_wvalid_i && s_axi_wready_o;
            step();
            core_done_i = 1'b0;
            if (a_acc) begin s_axi_awvalid_i = 1'b0; aw_pend = 1'b0; end
            if (w_acc) begin s_axi_wvalid_i = 1'b0; w_pend = 1'b0; end
            n++;
        end
        s_axi_awvalid_i = 1'b0; s_axi_wvalid_i = 1'b0;
        check("aw_w_accepted", {aw_pend, w_pend}, 0);
        n = 0;
        while (!s_axi_bvalid_o && n < 20) begin step(); n++; end
        check("bvalid_seen", s_axi_bvalid_o, 1);
        exp_resp = exp_b_q.pop_front();
        check("bresp", s_axi_bresp_o, exp_resp);
        step();
        check("bvalid_clear", s_axi_bvalid_o, 0);
    endtask

    task automatic axi_read(input logic [4:0] addr, input logic [31:0] data, input logic [1:0] resp,
                            input bit with_done);
        bit a_acc;
        int n;
        logic [33:0] exp_v;
        exp_r_q.push_back({resp, data});
        s_axi_araddr_i = addr; s_axi_arvalid_i = 1'b1; s_axi_rready_i = 1'b1;
        if (with_done) core_done_i = 1'b1;
        n = 0;
        while (!s_axi_rvalid_o && n < 20) begin
            a_acc = s_axi_arvalid_i && s_axi_arready_o;
            step();
            core_done_i = 1'b0;
            if (a_acc) s_axi_arvalid_i = 1'b0;
            n++;
        end
        s_axi_arvalid_i = 1'b0;
        check("rvalid_seen", s_axi_rvalid_o, 1);
        exp_v = exp_r_q.pop_front();
        check($sformatf("rdata@%0h", addr), s_axi_rdata_o, exp_v[31:0]);
        check($sformatf("rresp@%0h", addr), s_axi_rresp_o, exp_v[33:32]);
        step();
        check("rvalid_clear", s_axi_rvalid_o, 0);
    endtask

    task automatic pulse_done(input logic [31:0] res);
        core_result_i = res;
        core_done_i = 1'b1;
        step();
        core_done_i = 1'b0;
    endtask

    initial begin
        int s0;
        repeat (2) step();
        check("rst_awready", s_axi_awready_o, 1);
        check("rst_wready", s_axi_wready_o, 1);
        check("rst_arready", s_axi_arready_o, 1);
        check("rst_valids", {s_axi_bvalid_o, s_axi_rvalid_o, core_start_o, irq_o}, 0);
        check("rst_resp_data", {s_axi_bresp_o, s_axi_rresp_o, s_axi_rdata_o}, 0);
        check("rst_regs", {core_src_addr_o, core_dst_addr_o}, 0);
        check("rst_len", core_len_o, 0);
        reset_ni = 1'b1;
        step();

        // AW and W together
        axi_write(5'h08, 32'hDEADBEEF, 4'hF, 2'b00, 1'b0);
        check("src_out", core_src_addr_o, 32'hDEADBEEF);
        axi_read(5'h08, 32'hDEADBEEF, 2'b00, 1'b0);

        // W two cycles ahead of AW, partial strobe, B back-pressure
        s_axi_bready_i = 1'b0;
        s_axi_wdata_i = 32'hFFFF1234; s_axi_wstrb_i = 4'b0011; s_axi_wvalid_i = 1'b1;
        step();
        s_axi_wvalid_i = 1'b0;
        check("w_held_wready", s_axi_wready_o, 0);
        check("w_only_no_b", s_axi_bvalid_o, 0);
        step();
        s_axi_awaddr_i = 5'h10; s_axi_awvalid_i = 1'b1;
        step();
        s_axi_awvalid_i = 1'b0;
        check("len_out", core_len_o, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            s_axi_awaddr_i = 5'h08; s_axi_awvalid_i = 1'b1;
            check("b_hold_valid", s_axi_bvalid_o, 1);
            check("b_hold_resp", s_axi_bresp_o, 2'b00);
            check("b_hold_awready", s_axi_awready_o, 0);
            step();
        end
        s_axi_awvalid_i = 1'b0;
        s_axi_bready_i = 1'b1;
        step();
        check("b_release", s_axi_bvalid_o, 0);
        check("src_unchanged", core_src_addr_o, 32'hDEADBEEF);
        axi_read(5'h10, 32'h00001234, 2'b00, 1'b0);

        // Start pulse, then dropped start while busy
        s0 = start_cycles;
        axi_write(5'h00, 32'h1, 4'hF, 2'b00, 1'b0);
        check("start_pulse_cycles", start_cycles - s0, 1);
        core_busy_i = 1'b1;
        s0 = start_cycles;
        axi_write(5'h00, 32'h1, 4'hF, 2'b00, 1'b0);
        check("start_dropped_busy", start_cycles - s0, 0);
        axi_read(5'h04, 32'h1, 2'b00, 1'b0);
        core_busy_i = 1'b0;
        axi_read(5'h00, 32'h0, 2'b00, 1'b0);

        // Completion capture, W1C races, RESULT read race
        pulse_done(32'h00000042);
        axi_read(5'h14, 32'h42, 2'b00, 1'b0);
        axi_read(5'h04, 32'h2, 2'b00, 1'b0);
        axi_write(5'h04, 32'h2, 4'hF, 2'b00, 1'b1);
        axi_read(5'h04, 32'h2, 2'b00, 1'b0);
        axi_write(5'h04, 32'h2, 4'hE, 2'b00, 1'b0);
        axi_read(5'h04, 32'h2, 2'b00, 1'b0);
        axi_write(5'h04, 32'h2, 4'hF, 2'b00, 1'b0);
        axi_read(5'h04, 32'h0, 2'b00, 1'b0);
        core_result_i = 32'h99;
        axi_read(5'h14, 32'h42, 2'b00, 1'b1);
        axi_read(5'h14, 32'h99, 2'b00, 1'b0);
        axi_write(5'h14, 32'h1234, 4'hF, 2'b00, 1'b0);
        axi_read(5'h14, 32'h99, 2'b00, 1'b0);

`ifdef DSP_REGS_IRQ_EN
        axi_write(5'h1C, 32'h1, 4'hF, 2'b00, 1'b0);
        axi_write(5'h18, 32'h1, 4'hF, 2'b00, 1'b0);
        axi_read(5'h18, 32'h1, 2'b00, 1'b0);
        check("irq_idle", irq_o, 0);
        core_done_i = 1'b1;
        step();
        core_done_i = 1'b0;
        check("irq_not_yet", irq_o, 0);
        step();
        check("irq_set", irq_o, 1);
        axi_read(5'h1C, 32'h1, 2'b00, 1'b0);
        axi_write(5'h1C, 32'h1, 4'hF, 2'b00, 1'b0);
        check("irq_cleared", irq_o, 0);
`else
        axi_read(5'h1C, 32'h0, 2'b10, 1'b0);
        axi_read(5'h18, 32'h0, 2'b10, 1'b0);
        axi_write(5'h18, 32'h1, 4'hF, 2'b10, 1'b0);
        pulse_done(32'h7);
        step();
        check("irq_tied_low", irq_o, 0);
`endif

        // Reset with a read response pending and an AW held
        s_axi_rready_i = 1'b0;
        s_axi_araddr_i = 5'h08; s_axi_arvalid_i = 1'b1;
        step();
        s_axi_arvalid_i = 1'b0;
        check("pre_rst_rvalid", s_axi_rvalid_o, 1);
        check("pre_rst_rdata", s_axi_rdata_o, 32'hDEADBEEF);
        s_axi_awaddr_i = 5'h0C; s_axi_awvalid_i = 1'b1;
        step();
        s_axi_awvalid_i = 1'b0;
        check("pre_rst_aw_held", s_axi_awready_o, 0);
        reset_ni = 1'b0;
        #1;
        check("mid_rst_valids", {s_axi_rvalid_o, s_axi_bvalid_o}, 0);
        check("mid_rst_rdata", s_axi_rdata_o, 0);
        check("mid_rst_regs", {core_src_addr_o, core_dst_addr_o, core_len_o}, 0);
        check("mid_rst_awready", s_axi_awready_o, 1);
        step();
        reset_ni = 1'b1;
        s_axi_rready_i = 1'b1;
        s_axi_bready_i = 1'b1;
        s_axi_wdata_i = 32'h00005555; s_axi_wstrb_i = 4'hF; s_axi_wvalid_i = 1'b1;
        step();
        s_axi_wvalid_i = 1'b0;
        step();
        check("held_aw_discarded", s_axi_bvalid_o, 0);
        s_axi_awaddr_i = 5'h0C; s_axi_awvalid_i = 1'b1;
        step();
        s_axi_awvalid_i = 1'b0;
        check("post_rst_bvalid", s_axi_bvalid_o, 1);
        check("post_rst_dst", core_dst_addr_o, 32'h5555);
        step();
        axi_read(5'h0C, 32'h5555, 2'b00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
